// File: rtl/stopwatch_core.sv
// BCD stopwatch core: counts 0:00.00 .. 1:59.99 in 10 ms ticks with a run/pause/clear FSM
// and a timed full-scale alarm. All outputs come straight from registers.
module stopwatch_core #(
    parameter int unsigned ALARM_TICKS = 300
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_en,
    input  logic       start_stop_in,
    input  logic       clear_in,
    output logic [3:0] ms_bcd_tens_out,
    output logic [3:0] ms_bcd_ones_out,
    output logic [3:0] sec_bcd_tens_out,
    output logic [3:0] sec_bcd_ones_out,
    output logic       min_out,
    output logic       alarm_active_out,
    output logic       running_out,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_ALARM = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [9:0] ALARM_LAST = 10'(ALARM_TICKS - 32'd1);

    // Advance one BCD digit; any value at or above top rolls to zero so a digit can never stick out of range.
    function automatic logic [4:0] bcd_step(input logic [3:0] digit, input logic [3:0] top, input logic cin);
        logic [4:0] res;
        if (!cin) begin
            res = {1'b0, digit};
        end else if (digit >= top) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, digit + 4'd1};
        end
        return res;
    endfunction

    state_t     state_r, state_s;
    logic [3:0] ms_ones_r, ms_tens_r, sec_ones_r, sec_tens_r;
    logic [3:0] ms_ones_s, ms_tens_s, sec_ones_s, sec_tens_s;
    logic       min_r, min_s;
    logic [9:0] acnt_r, acnt_s;
    logic       alarm_r, alarm_s;
    logic       running_r, running_s;

    logic [3:0] ms_ones_inc_s, ms_tens_inc_s, sec_ones_inc_s, sec_tens_inc_s;
    logic       c0_s, c1_s, c2_s, c3_s;
    logic       min_inc_s;
    logic       full_next_s;

    // Incremented count as if a tick were applied now, plus detection of landing on full scale.
    always_comb begin
        {c0_s, ms_ones_inc_s}  = bcd_step(ms_ones_r,  4'd9, 1'b1);
        {c1_s, ms_tens_inc_s}  = bcd_step(ms_tens_r,  4'd9, c0_s);
        {c2_s, sec_ones_inc_s} = bcd_step(sec_ones_r, 4'd9, c1_s);
        {c3_s, sec_tens_inc_s} = bcd_step(sec_tens_r, 4'd5, c2_s);
        min_inc_s   = min_r | c3_s;
        full_next_s = min_inc_s && (sec_tens_inc_s == 4'd5) && (sec_ones_inc_s == 4'd9)
                      && (ms_tens_inc_s == 4'd9) && (ms_ones_inc_s == 4'd9);
    end

    // Next state, next count and next alarm counter in transition priority order.
    always_comb begin
        state_s    = state_r;
        ms_ones_s  = ms_ones_r;
        ms_tens_s  = ms_tens_r;
        sec_ones_s = sec_ones_r;
        sec_tens_s = sec_tens_r;
        min_s      = min_r;
        acnt_s     = acnt_r;
        if (clear_in) begin
            state_s    = ST_IDLE;
            ms_ones_s  = 4'd0;
            ms_tens_s  = 4'd0;
            sec_ones_s = 4'd0;
            sec_tens_s = 4'd0;
            min_s      = 1'b0;
            acnt_s     = 10'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_stop_in) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tick_en) begin
                        ms_ones_s  = ms_ones_inc_s;
                        ms_tens_s  = ms_tens_inc_s;
                        sec_ones_s = sec_ones_inc_s;
                        sec_tens_s = sec_tens_inc_s;
                        min_s      = min_inc_s;
                    end else begin
                        min_s      = min_r;
                    end
                    // Reaching full scale wins over a simultaneous pause request.
                    if (tick_en && full_next_s) begin
                        state_s = ST_ALARM;
                        acnt_s  = 10'd0;
                    end else if (start_stop_in) begin
                        state_s = ST_PAUSE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (start_stop_in) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_ALARM: begin
                    if (tick_en && (acnt_r >= ALARM_LAST)) begin
                        state_s = ST_DONE;
                    end else if (tick_en) begin
                        acnt_s  = acnt_r + 10'd1;
                    end else begin
                        state_s = ST_ALARM;
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s    = ST_IDLE;
                    ms_ones_s  = 4'd0;
                    ms_tens_s  = 4'd0;
                    sec_ones_s = 4'd0;
                    sec_tens_s = 4'd0;
                    min_s      = 1'b0;
                    acnt_s     = 10'd0;
                end
            endcase
        end
        running_s = (state_s == ST_RUN);
        alarm_s   = (state_s == ST_ALARM);
    end

    // State, count and status flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            ms_ones_r  <= 4'd0;
            ms_tens_r  <= 4'd0;
            sec_ones_r <= 4'd0;
            sec_tens_r <= 4'd0;
            min_r      <= 1'b0;
            acnt_r     <= 10'd0;
            alarm_r    <= 1'b0;
            running_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            ms_ones_r  <= ms_ones_s;
            ms_tens_r  <= ms_tens_s;
            sec_ones_r <= sec_ones_s;
            sec_tens_r <= sec_tens_s;
            min_r      <= min_s;
            acnt_r     <= acnt_s;
            alarm_r    <= alarm_s;
            running_r  <= running_s;
        end
    end

    assign ms_bcd_ones_out  = ms_ones_r;
    assign ms_bcd_tens_out  = ms_tens_r;
    assign sec_bcd_ones_out = sec_ones_r;
    assign sec_bcd_tens_out = sec_tens_r;
    assign min_out          = min_r;
    assign alarm_active_out = alarm_r;
    assign running_out      = running_r;
    assign state_out        = state_r;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: integer-hundredths model compared every cycle, plus literal spot checks.
module tb_stopwatch_core;

    localparam int AT = 3;
    localparam logic [21:0] M_ALL = 22'h3FFFFF;

    logic       clk = 1'b0;
    logic       reset_n, tick_en, start_stop_in, clear_in;
    logic [3:0] ms_bcd_tens_out, ms_bcd_ones_out, sec_bcd_tens_out, sec_bcd_ones_out;
    logic       min_out, alarm_active_out, running_out;
    logic [2:0] state_out;

    stopwatch_core #(.ALARM_TICKS(AT)) dut (
        .clk(clk), .reset_n(reset_n), .tick_en(tick_en),
        .start_stop_in(start_stop_in), .clear_in(clear_in),
        .ms_bcd_tens_out(ms_bcd_tens_out), .ms_bcd_ones_out(ms_bcd_ones_out),
        .sec_bcd_tens_out(sec_bcd_tens_out), .sec_bcd_ones_out(sec_bcd_ones_out),
        .min_out(min_out), .alarm_active_out(alarm_active_out),
        .running_out(running_out), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    // Model: elapsed time as integer hundredths, state code, alarm ticks seen.
    int m_count = 0;
    int m_state = 0;
    int m_acnt  = 0;

    int           lit_req = 0;
    int           lit_done = 0;
    logic [21:0]  lit_exp;
    string        lit_name;

    logic [21:0] dut_vec;
    assign dut_vec = {min_out, sec_bcd_tens_out, sec_bcd_ones_out, ms_bcd_tens_out, ms_bcd_ones_out,
                      alarm_active_out, running_out, state_out};

    function automatic logic [21:0] mk(int mn, int st, int so, int mt, int mo, int al, int rn, int s);
        return {1'(mn), 4'(st), 4'(so), 4'(mt), 4'(mo), 1'(al), 1'(rn), 3'(s)};
    endfunction

    function automatic logic [21:0] model_vec();
        int rem, sec, hs;
        rem = m_count % 6000;
        sec = rem / 100;
        hs  = rem % 100;
        return mk(m_count / 6000, sec / 10, sec % 10, hs / 10, hs % 10,
                  (m_state == 3) ? 1 : 0, (m_state == 1) ? 1 : 0, m_state);
    endfunction

    // Per-cycle model compare plus any pending literal expectation.
    always @(negedge clk) begin
        int n, f;
        logic [21:0] e;
        n = 1;
        f = 0;
        e = model_vec();
        if (dut_vec !== e) begin
            f = f + 1;
            $display("FAIL model_cycle t=%0t got %h expected %h", $time, dut_vec, e);
        end
        if (lit_req != lit_done) begin
            n = n + 1;
            if (dut_vec !== lit_exp) begin
                f = f + 1;
                $display("FAIL %s t=%0t got %h expected %h", lit_name, $time, dut_vec, lit_exp);
            end
        end
        lit_done    <= lit_req;
        vectors     <= vectors + n;
        miscompares <= miscompares + f;
    end

    task automatic expect_lit(input logic [21:0] exp, input string name);
        lit_exp  = exp;
        lit_name = name;
        lit_req  = lit_req + 1;
    endtask

    task automatic step(input logic t, input logic s, input logic c);
        int nc, ns, na;
        tick_en = t; start_stop_in = s; clear_in = c;
        nc = m_count; ns = m_state; na = m_acnt;
        if (c) begin
            nc = 0; ns = 0; na = 0;
        end else begin
            case (m_state)
                0: if (s) ns = 1;
                1: begin
                    if (t) nc = m_count + 1;
                    if (t && nc == 11999) begin ns = 3; na = 0; end
                    else if (s) ns = 2;
                end
                2: if (s) ns = 1;
                3: if (t) begin
                    if (m_acnt == AT - 1) ns = 4;
                    else na = m_acnt + 1;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        m_count = nc; m_state = ns; m_acnt = na;
        tick_en = 1'b0; start_stop_in = 1'b0; clear_in = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; tick_en = 1'b0; start_stop_in = 1'b0; clear_in = 1'b0;
        #2;
        expect_lit(22'd0, "reset_state");
        #20;
        reset_n = 1'b1;
        @(posedge clk); #1;

        ticks(250);
        expect_lit(mk(0, 0, 0, 0, 0, 0, 0, 0), "idle_ticks_ignored");
        step(1'b0, 1'b1, 1'b0);
        ticks(1234);
        expect_lit(mk(0, 1, 2, 3, 4, 0, 1, 1), "run_12_34");

        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        ticks(5999);
        expect_lit(mk(0, 5, 9, 9, 9, 0, 1, 1), "run_59_99");
        ticks(1);
        expect_lit(mk(1, 0, 0, 0, 0, 0, 1, 1), "minute_carry");
        repeat (3) step(1'b0, 1'b0, 1'b0);
        ticks(5998);
        expect_lit(mk(1, 5, 9, 9, 8, 0, 1, 1), "run_1_59_98");
        step(1'b1, 1'b1, 1'b0);
        expect_lit(mk(1, 5, 9, 9, 9, 1, 0, 3), "full_scale_alarm");
        step(1'b0, 1'b1, 1'b0);
        ticks(2);
        expect_lit(mk(1, 5, 9, 9, 9, 1, 0, 3), "alarm_second_tick");
        ticks(1);
        expect_lit(mk(1, 5, 9, 9, 9, 0, 0, 4), "alarm_to_done");
        step(1'b0, 1'b1, 1'b0);
        ticks(4);
        expect_lit(mk(1, 5, 9, 9, 9, 0, 0, 4), "done_holds");
        step(1'b0, 1'b0, 1'b1);
        expect_lit(mk(0, 0, 0, 0, 0, 0, 0, 0), "clear_from_done");

        step(1'b0, 1'b1, 1'b0);
        ticks(50);
        step(1'b1, 1'b1, 1'b0);
        expect_lit(mk(0, 0, 0, 5, 1, 0, 0, 2), "pause_counts_tick");
        ticks(20);
        expect_lit(mk(0, 0, 0, 5, 1, 0, 0, 2), "pause_holds");
        step(1'b1, 1'b1, 1'b0);
        expect_lit(mk(0, 0, 0, 5, 1, 0, 1, 1), "resume_no_count");
        ticks(1);
        expect_lit(mk(0, 0, 0, 5, 2, 0, 1, 1), "resume_then_count");

        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        ticks(700);
        expect_lit(mk(0, 0, 7, 0, 0, 0, 1, 1), "run_7_00");
        step(1'b1, 1'b1, 1'b1);
        expect_lit(mk(0, 0, 0, 0, 0, 0, 0, 0), "clear_priority");

        step(1'b1, 1'b1, 1'b0);
        expect_lit(mk(0, 0, 0, 0, 0, 0, 1, 1), "start_tick_not_counted");
        ticks(37);
        expect_lit(mk(0, 0, 0, 3, 7, 0, 1, 1), "run_0_37");
        ticks(1);
        reset_n = 1'b0;
        m_count = 0; m_state = 0; m_acnt = 0;
        expect_lit(mk(0, 0, 0, 0, 0, 0, 0, 0), "async_reset_mid_run");
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        ticks(5);
        expect_lit(mk(0, 0, 0, 0, 0, 0, 0, 0), "idle_after_reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
